// File: rtl/if_id_stage.sv
// Fetch stage: owns the PC, drives the instruction ROM and registers IF/ID with a pre-decoded EXTop.
// Optional build macro IF_ID_PERF_CNT_EN adds saturating stall/flush event counters.
module if_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] irom_addr,
  input  logic [31:0] irom_inst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_inst,
  output logic [24:0] id_imm_field,
  output logic [2:0]  id_extop,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [2:0]  fetch_extop;

  // Immediate-format select; unknown opcodes map to 3'b111 so the extender emits zero.
  function automatic logic [2:0] extop_decode(input logic [6:0] op);
    logic [2:0] sel;
    case (op)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: sel = 3'b000;
      7'b0100011:                                      sel = 3'b001;
      7'b1100011:                                      sel = 3'b010;
      7'b0110111, 7'b0010111:                          sel = 3'b011;
      7'b1101111:                                      sel = 3'b100;
      default:                                         sel = 3'b111;
    endcase
    return sel;
  endfunction

  assign irom_addr    = pc;
  assign pc_plus4     = pc + 32'd4;
  assign fetch_extop  = extop_decode(irom_inst[6:0]);
  assign id_imm_field = id_inst[31:7];

  // Redirect takes priority over stall so a taken branch is never lost behind a hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[31:2], 2'b00};
    end else if (!stall) begin
      pc <= pc_plus4;
    end
  end

  // Flush wins over stall: a squashed slot becomes a bubble even while the pipe is frozen.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_inst  <= NOP_INST;
      id_extop <= 3'b000;
      id_pc    <= 32'd0;
      id_pc4   <= 32'd0;
      id_valid <= 1'b0;
    end else if (!stall) begin
      id_inst  <= irom_inst;
      id_extop <= fetch_extop;
      id_pc    <= pc;
      id_pc4   <= pc_plus4;
      id_valid <= 1'b1;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (flush && (perf_flush_cnt != 32'hFFFF_FFFF)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios with literal expectations, then random control traffic
// compared every cycle against a behavioural fetch model.
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, stall, flush, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] irom_addr, irom_inst;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic [24:0] id_imm_field;
  logic [2:0]  id_extop;
  logic        id_valid;
`ifdef IF_ID_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .irom_addr(irom_addr), .irom_inst(irom_inst),
    .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_inst(id_inst), .id_imm_field(id_imm_field), .id_extop(id_extop),
    .id_pc(id_pc), .id_pc4(id_pc4), .id_valid(id_valid)
`ifdef IF_ID_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  // ROM image: fixed words at 0/4, elsewhere a scrambled word whose opcode cycles through a table.
  function automatic logic [31:0] rom(input logic [31:0] a);
    logic [31:0] h;
    logic [6:0]  op;
    if (a == 32'd0) return 32'h0050_0093;
    if (a == 32'd4) return 32'h0010_2023;
    h = a * 32'h9E37_79B1;
    case (a[5:2])
      4'd0:  op = 7'b0010011;  4'd1:  op = 7'b0100011;
      4'd2:  op = 7'b1100011;  4'd3:  op = 7'b0110111;
      4'd4:  op = 7'b1101111;  4'd5:  op = 7'b0110011;
      4'd6:  op = 7'b0000011;  4'd7:  op = 7'b1100111;
      4'd8:  op = 7'b1110011;  4'd9:  op = 7'b0010111;
      4'd10: op = 7'b0000000;  4'd11: op = 7'b1111111;
      4'd12: op = 7'b0001111;  4'd13: op = 7'b1100011;
      4'd14: op = 7'b0100011;  default: op = 7'b0010011;
    endcase
    return {h[31:7], op};
  endfunction

  assign irom_inst = rom(irom_addr);

  function automatic logic [2:0] fmt_of(input logic [6:0] op);
    if (op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011}) return 3'd0;
    if (op == 7'b0100011) return 3'd1;
    if (op == 7'b1100011) return 3'd2;
    if (op inside {7'b0110111, 7'b0010111}) return 3'd3;
    if (op == 7'b1101111) return 3'd4;
    return 3'd7;
  endfunction

  // Reference model state
  logic [31:0] m_pc, m_inst, m_ipc, m_ipc4, m_scnt, m_fcnt;
  logic [2:0]  m_ext;
  logic        m_valid;

  always @(posedge clk) begin
    logic [31:0] nxt;
    if (rst) begin
      m_pc = 32'd0; m_inst = NOP; m_ext = 3'd0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_valid = 1'b0;
      m_scnt = 32'd0; m_fcnt = 32'd0;
    end else begin
      if (stall && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
      if (flush && m_fcnt != 32'hFFFF_FFFF) m_fcnt = m_fcnt + 1;
      nxt = redirect_valid ? (redirect_pc & ~32'd3) : (stall ? m_pc : m_pc + 32'd4);
      if (flush) begin
        m_inst = NOP; m_ext = 3'd0; m_ipc = 32'd0; m_ipc4 = 32'd0; m_valid = 1'b0;
      end else if (!stall) begin
        m_inst = rom(m_pc); m_ext = fmt_of(m_inst[6:0]);
        m_ipc = m_pc; m_ipc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = nxt;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic checkOutput();
    cmp("irom_addr", irom_addr, m_pc);
    cmp("id_inst", id_inst, m_inst);
    cmp("id_imm_field", {7'd0, id_imm_field}, {7'd0, m_inst[31:7]});
    cmp("id_extop", {29'd0, id_extop}, {29'd0, m_ext});
    cmp("id_pc", id_pc, m_ipc);
    cmp("id_pc4", id_pc4, m_ipc4);
    cmp("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
`ifdef IF_ID_PERF_CNT_EN
    cmp("perf_stall_cnt", perf_stall_cnt, m_scnt);
    cmp("perf_flush_cnt", perf_flush_cnt, m_fcnt);
`endif
  endtask

  always @(negedge clk) if (chk_en) checkOutput();

  // Drive one cycle of controls, then return just after the following rising edge.
  task automatic applyStimulus(input logic r, input logic s, input logic f,
                               input logic rv, input logic [31:0] rp);
    rst = r; stall = s; flush = f; redirect_valid = rv; redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    applyStimulus(1, 0, 0, 0, 0);
    chk_en = 1'b1;
    applyStimulus(1, 1, 1, 1, 32'h55);
    cmp("reset irom_addr", irom_addr, 32'd0);
    cmp("reset id_inst", id_inst, NOP);
    cmp("reset id_valid", {31'd0, id_valid}, 32'd0);
    cmp("reset id_pc", id_pc, 32'd0);

    applyStimulus(0, 0, 0, 0, 0);
    cmp("edge1 id_pc", id_pc, 32'd0);
    cmp("edge1 id_pc4", id_pc4, 32'd4);
    cmp("edge1 id_inst", id_inst, 32'h0050_0093);
    cmp("edge1 id_extop", {29'd0, id_extop}, 32'd0);
    cmp("edge1 id_valid", {31'd0, id_valid}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("edge2 id_pc", id_pc, 32'd4);
    cmp("edge2 id_extop", {29'd0, id_extop}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0);
      cmp("stall irom_addr", irom_addr, 32'd8);
      cmp("stall id_pc", id_pc, 32'd4);
    end
    applyStimulus(0, 0, 0, 0, 0);
    cmp("release id_pc", id_pc, 32'd8);

    applyStimulus(0, 0, 1, 1, 32'h0000_0103);
    cmp("redir irom_addr", irom_addr, 32'h100);
    cmp("redir id_valid", {31'd0, id_valid}, 32'd0);
    cmp("redir id_inst", id_inst, NOP);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("redir+1 id_pc", id_pc, 32'h100);
    cmp("redir+1 id_valid", {31'd0, id_valid}, 32'd1);

    applyStimulus(0, 1, 1, 1, 32'h40);
    cmp("all3 irom_addr", irom_addr, 32'h40);
    cmp("all3 id_valid", {31'd0, id_valid}, 32'd0);
    cmp("all3 id_pc", id_pc, 32'd0);

    applyStimulus(0, 0, 1, 1, 32'h108);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("sweep B", {29'd0, id_extop}, 32'd2);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("sweep U", {29'd0, id_extop}, 32'd3);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("sweep J", {29'd0, id_extop}, 32'd4);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("sweep R", {29'd0, id_extop}, 32'd7);

    applyStimulus(0, 0, 1, 1, 32'hFFFF_FFFE);
    cmp("wrap irom_addr", irom_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 0);
    cmp("wrap next pc", irom_addr, 32'd0);
    cmp("wrap id_pc", id_pc, 32'hFFFF_FFFC);
    cmp("wrap id_pc4", id_pc4, 32'd0);

    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 1, 0, 0);
`ifdef IF_ID_PERF_CNT_EN
    cmp("perf stall=5", perf_stall_cnt, 32'd5);
    cmp("perf flush=2", perf_flush_cnt, 32'd2);
`endif

    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
      applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0, tgt);
    end

    @(negedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
